// File: rtl/mult_seq.sv
// Sequential shift-add multiplier controller: a Moore FSM that steers an external datapath.
// Define MULT_SEQ_EARLY_EXIT_EN to finish as soon as the multiplier register reaches zero.
module mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic                   MPLR_LSB,
  input  logic                   MPLR_ZERO,
  output logic [1:0]             SEL_A,
  output logic [1:0]             SEL_B,
  output logic                   CLR,
  output logic                   LD,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [$clog2(WIDTH):0] CYC_CNT
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  localparam logic [1:0] SelHold  = 2'b00;
  localparam logic [1:0] SelLoad  = 2'b01;
  localparam logic [1:0] SelShl   = 2'b10;
  localparam logic [1:0] SelShr   = 2'b11;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StTest  = 3'd2,
    StAdd   = 3'd3,
    StShift = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            finish;

  // Termination condition evaluated in TEST; early exit has priority over ADD/SHIFT.
`ifdef MULT_SEQ_EARLY_EXIT_EN
  assign finish = MPLR_ZERO || (cnt_q == CntMax);
`else
  logic unused_mplr_zero;
  assign unused_mplr_zero = MPLR_ZERO;
  assign finish = (cnt_q == CntMax);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (START) state_d = StLoad;
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StTest;
      end
      StTest: begin
        if (finish)        state_d = StDone;
        else if (MPLR_LSB) state_d = StAdd;
        else               state_d = StShift;
      end
      StAdd: begin
        state_d = StShift;
      end
      StShift: begin
        // Saturate so the count can never pass WIDTH.
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        state_d = StTest;
      end
      StDone: begin
        // Wait for button release so a held START never retriggers.
        if (!START) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore output decode.
  always_comb begin
    SEL_A = SelHold;
    SEL_B = SelHold;
    CLR   = 1'b0;
    LD    = 1'b0;
    BUSY  = 1'b0;
    DONE  = 1'b0;
    case (state_q)
      StLoad: begin
        SEL_A = SelLoad;
        SEL_B = SelLoad;
        CLR   = 1'b1;
        BUSY  = 1'b1;
      end
      StTest: begin
        BUSY = 1'b1;
      end
      StAdd: begin
        LD   = 1'b1;
        BUSY = 1'b1;
      end
      StShift: begin
        SEL_A = SelShl;
        SEL_B = SelShr;
        BUSY  = 1'b1;
      end
      StDone: begin
        DONE = 1'b1;
      end
      default: ;
    endcase
  end

  assign CYC_CNT = cnt_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: models the shift-add datapath around the controller and checks
// iteration counts, latency, product and handshake corner cases against hand-computed values.
module tb_mult_seq;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START;
  logic       MPLR_LSB;
  logic       MPLR_ZERO;
  logic [1:0] SEL_A;
  logic [1:0] SEL_B;
  logic       CLR;
  logic       LD;
  logic       BUSY;
  logic       DONE;
  logic [3:0] CYC_CNT;

  int checks = 0;
  int errors = 0;

  mult_seq #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .MPLR_LSB  (MPLR_LSB),
    .MPLR_ZERO (MPLR_ZERO),
    .SEL_A     (SEL_A),
    .SEL_B     (SEL_B),
    .CLR       (CLR),
    .LD        (LD),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .CYC_CNT   (CYC_CNT)
  );

  always #5 CLK = ~CLK;

  // Datapath model driven by the controller outputs.
  logic [7:0]  opa = '0;
  logic [7:0]  opb = '0;
  logic [7:0]  mplr = '0;
  logic [15:0] mcand = '0;
  logic [15:0] acc = '0;

  always @(posedge CLK) begin
    if (SEL_A == 2'b01)      mcand <= {8'd0, opa};
    else if (SEL_A == 2'b10) mcand <= mcand << 1;
    if (SEL_B == 2'b01)      mplr <= opb;
    else if (SEL_B == 2'b11) mplr <= mplr >> 1;
    if (CLR)                 acc <= '0;
    else if (LD)             acc <= acc + mcand;
  end

  assign MPLR_LSB  = mplr[0];
  assign MPLR_ZERO = (mplr == 8'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: one-cycle START pulse, 1: START held, 2: START toggled every busy cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int mode,
                        output int adds, output int shifts, output int lat,
                        output bit timed_out, output bit bad_ctl);
    int cyc;
    opa = a;
    opb = b;
    adds = 0;
    shifts = 0;
    lat = 0;
    timed_out = 1'b0;
    bad_ctl = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    chk("load_state", {SEL_A, SEL_B, CLR, BUSY, LD}, {2'b01, 2'b01, 1'b1, 1'b1, 1'b0});
    if (mode == 0) START = 1'b0;
    cyc = 0;
    while (!DONE && cyc < 200) begin
      if (mode == 2) START = ~START;
      @(negedge CLK);
      cyc++;
      if (LD) adds++;
      if (SEL_A == 2'b10) shifts++;
      if (!DONE && !BUSY) bad_ctl = 1'b1;
      if (LD && CLR) bad_ctl = 1'b1;
      if (DONE && (SEL_A != 2'b00 || SEL_B != 2'b00 || LD || CLR)) bad_ctl = 1'b1;
    end
    lat = cyc;
    if (!DONE) timed_out = 1'b1;
    if (mode != 1) START = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          adds;
    int          shifts;
    int          lat;
    logic [3:0]  cnt;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  adds, shifts, lat, loads;
    bit  to, bad;

    vecs[0] = '{8'h37, 8'hA5, 4, 8, 22, 4'd8, 16'h2373};
    vecs[3] = '{8'hFF, 8'hFF, 8, 8, 26, 4'd8, 16'hFE01};
    vecs[4] = '{8'h02, 8'h80, 1, 8, 19, 4'd8, 16'h0100};
`ifdef MULT_SEQ_EARLY_EXIT_EN
    vecs[1] = '{8'h55, 8'h03, 2, 2, 8,  4'd2, 16'h00FF};
    vecs[2] = '{8'hFF, 8'h00, 0, 0, 2,  4'd0, 16'h0000};
    vecs[5] = '{8'h9C, 8'h01, 1, 1, 5,  4'd1, 16'h009C};
`else
    vecs[1] = '{8'h55, 8'h03, 2, 8, 20, 4'd8, 16'h00FF};
    vecs[2] = '{8'hFF, 8'h00, 0, 8, 18, 4'd8, 16'h0000};
    vecs[5] = '{8'h9C, 8'h01, 1, 8, 19, 4'd8, 16'h009C};
`endif

    RST_N = 1'b0;
    START = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_outputs", {SEL_A, SEL_B, CLR, LD, BUSY, DONE}, 8'h00);
    chk("reset_cnt", {28'd0, CYC_CNT}, 32'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_no_start", {SEL_A, SEL_B, CLR, LD, BUSY, DONE}, 8'h00);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, adds, shifts, lat, to, bad);
      chk($sformatf("v%0d_timeout", i), {31'd0, to}, 32'd0);
      chk($sformatf("v%0d_ctl", i), {31'd0, bad}, 32'd0);
      chk($sformatf("v%0d_adds", i), adds, vecs[i].adds);
      chk($sformatf("v%0d_shifts", i), shifts, vecs[i].shifts);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_cnt", i), {28'd0, CYC_CNT}, {28'd0, vecs[i].cnt});
      chk($sformatf("v%0d_prod", i), {16'd0, acc}, {16'd0, vecs[i].prod});
      @(negedge CLK);
      chk($sformatf("v%0d_idle", i), {30'd0, BUSY, DONE}, 32'd0);
      chk($sformatf("v%0d_cnt_hold", i), {28'd0, CYC_CNT}, {28'd0, vecs[i].cnt});
    end

    // START toggling while busy must not alter the sequence.
    run_op(8'h37, 8'hA5, 2, adds, shifts, lat, to, bad);
    chk("tog_adds", adds, 4);
    chk("tog_shifts", shifts, 8);
    chk("tog_latency", lat, 22);
    chk("tog_prod", {16'd0, acc}, 32'h2373);
    @(negedge CLK);
    chk("tog_idle", {30'd0, BUSY, DONE}, 32'd0);

    // START held through completion: stay in DONE, no retrigger.
    run_op(8'h05, 8'h06, 1, adds, shifts, lat, to, bad);
    chk("hold_timeout", {31'd0, to}, 32'd0);
    chk("hold_prod", {16'd0, acc}, 32'h001E);
    loads = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (SEL_A == 2'b01 || !DONE) loads++;
    end
    chk("hold_stay_done", loads, 0);
    chk("hold_done_flag", {31'd0, DONE}, 32'd1);
    START = 1'b0;
    @(negedge CLK);
    chk("release_idle", {30'd0, BUSY, DONE}, 32'd0);
    loads = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (SEL_A == 2'b01 || BUSY) loads++;
    end
    chk("release_no_reload", loads, 0);

    // Asynchronous reset landing between edges while in SHIFT.
    opa = 8'h37;
    opb = 8'hA5;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    begin
      int n;
      n = 0;
      while (SEL_A != 2'b10 && n < 50) begin
        @(negedge CLK);
        n++;
      end
      chk("rst_reach_shift", {30'd0, SEL_A}, 32'd2);
    end
    #2 RST_N = 1'b0;
    #1;
    chk("rst_async_ctl", {SEL_A, SEL_B, LD, BUSY}, 6'h00);
    chk("rst_async_cnt", {28'd0, CYC_CNT}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (SEL_A != 2'b00 || SEL_B != 2'b00 || CLR || LD || BUSY) loads++;
    end
    chk("rst_wait_start", loads, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
